// File: rtl/ope_fetch_aligner.sv
// Byte-serial instruction fetcher: pulls opcode and argument bytes from memory and presents
// one aligned instruction word per transfer. Optional feature macro: ALIGN_ILLEGAL_TRAP_EN.
module ope_fetch_aligner #(
  parameter logic [31:0] RESET_EIP = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [7:0]  mem_data,
  input  logic        mem_valid,
  input  logic        eip_load,
  input  logic [31:0] eip_in,
  output logic [31:0] ope,
  output logic [3:0]  num_of_ope,
  output logic        ope_valid,
  input  logic        ope_ready,
  output logic        illegal
);

  typedef enum logic [2:0] {
    StFetchOp,
    StFetchArg,
    StSkip,
    StPresent,
    StTrap
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ope_q, ope_d;
  logic [3:0]  num_q, num_d;
  logic [1:0]  idx_q, idx_d;
  logic        ope_valid_q, ope_valid_d;
  logic        illegal_q, illegal_d;
  logic        mem_req_q, mem_req_d;

  logic        accept;
  logic [3:0]  op_len_raw;
  logic [3:0]  len_eff;
  logic [1:0]  last_idx;

  // Returns 0 for opcodes outside the length table.
  function automatic logic [3:0] op_len(input logic [7:0] op);
    case (op)
      8'h55, 8'h53, 8'h5d, 8'hc3, 8'hc9: op_len = 4'd1;
      8'h89, 8'h6a:                      op_len = 4'd2;
      8'h8b, 8'h83:                      op_len = 4'd3;
      8'hb8, 8'he8:                      op_len = 4'd5;
      default:                           op_len = 4'd0;
    endcase
  endfunction

  // Memory responses only count while a request is actually outstanding.
  assign accept     = mem_valid & mem_req_q;
  assign op_len_raw = op_len(mem_data);
  assign len_eff    = (op_len_raw == 4'd0) ? 4'd1 : op_len_raw;
  // Lane index of the last argument byte kept; a 5th byte is fetched and dropped.
  assign last_idx   = (num_q >= 4'd4) ? 2'd3 : 2'(num_q - 4'd1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ope_d       = ope_q;
    num_d       = num_q;
    idx_d       = idx_q;
    ope_valid_d = ope_valid_q;
    illegal_d   = illegal_q;

    unique case (state_q)
      StFetchOp: begin
        if (accept) begin
          ope_d     = {mem_data, 24'h000000};
          pc_d      = pc_q + 32'd1;
          illegal_d = (op_len_raw == 4'd0);
          num_d     = len_eff;
          idx_d     = 2'd1;
          state_d   = (len_eff == 4'd1) ? StPresent : StFetchArg;
        end
      end
      StFetchArg: begin
        if (accept) begin
          case (idx_q)
            2'd1:    ope_d[23:16] = mem_data;
            2'd2:    ope_d[15:8]  = mem_data;
            default: ope_d[7:0]   = mem_data;
          endcase
          pc_d  = pc_q + 32'd1;
          idx_d = idx_q + 2'd1;
          if (idx_q == last_idx) begin
            state_d = (num_q <= 4'd4) ? StPresent : StSkip;
          end
        end
      end
      StSkip: begin
        if (accept) begin
          pc_d    = pc_q + 32'd1;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (!ope_valid_q) begin
          ope_valid_d = 1'b1;
        end else if (ope_ready) begin
          ope_valid_d = 1'b0;
`ifdef ALIGN_ILLEGAL_TRAP_EN
          state_d     = illegal_q ? StTrap : StFetchOp;
`else
          illegal_d   = 1'b0;
          state_d     = StFetchOp;
`endif
        end
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StFetchOp;
      end
    endcase

    // Redirect beats everything, including a byte arriving this same cycle.
    if (eip_load) begin
      pc_d        = eip_in;
      ope_valid_d = 1'b0;
      illegal_d   = 1'b0;
      idx_d       = 2'd1;
      state_d     = StFetchOp;
    end

    mem_req_d = (state_d == StFetchOp) || (state_d == StFetchArg) || (state_d == StSkip);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StFetchOp;
      pc_q        <= RESET_EIP;
      ope_q       <= 32'h00000000;
      num_q       <= 4'd0;
      idx_q       <= 2'd1;
      ope_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      mem_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ope_q       <= ope_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      ope_valid_q <= ope_valid_d;
      illegal_q   <= illegal_d;
      mem_req_q   <= mem_req_d;
    end
  end

  assign mem_addr   = pc_q;
  assign mem_req    = mem_req_q;
  assign ope        = ope_q;
  assign num_of_ope = num_q;
  assign ope_valid  = ope_valid_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_ope_fetch_aligner.sv
// Directed bench for ope_fetch_aligner: byte memory model with stall control and
// hand-computed expected instruction words, addresses and latencies.
module tb_ope_fetch_aligner;

  logic        clock;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic        eip_load;
  logic [31:0] eip_in;
  logic [31:0] ope;
  logic [3:0]  num_of_ope;
  logic        ope_valid;
  logic        ope_ready;
  logic        illegal;

  logic [7:0]  mem [256];
  logic        stall;
  int          checks;
  int          failures;
  int          fetches;

  ope_fetch_aligner #(.RESET_EIP(32'h00000000)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .eip_load   (eip_load),
    .eip_in     (eip_in),
    .ope        (ope),
    .num_of_ope (num_of_ope),
    .ope_valid  (ope_valid),
    .ope_ready  (ope_ready),
    .illegal    (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_data  = mem[mem_addr[7:0]];
  assign mem_valid = mem_req & ~stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Counts accepted bytes until ope_valid rises; a blown budget is reported as a failure.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (ope_valid) break;
      if (mem_req && mem_valid) n++;
      step();
    end
    check_eq({tag, "_valid"}, {31'd0, ope_valid}, 32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    eip_load  = 1'b0;
    eip_in    = 32'h0;
    ope_ready = 1'b0;
    stall     = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h55;
    mem[8'h05] = 8'h0f;
    mem[8'h06] = 8'hc9;
    mem[8'h10] = 8'he8; mem[8'h11] = 8'hf0; mem[8'h12] = 8'hff;
    mem[8'h13] = 8'hff; mem[8'h14] = 8'hff;
    mem[8'h15] = 8'h8b; mem[8'h16] = 8'h45; mem[8'h17] = 8'hfc;
    mem[8'h18] = 8'h5d;
    mem[8'h19] = 8'hb8; mem[8'h1a] = 8'h11; mem[8'h1b] = 8'h22;
    mem[8'h40] = 8'hc3;
    mem[8'hff] = 8'h6a;

    // Reset state
    step(); step();
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_ope", ope, 32'h0);
    check_eq("rst_num", {28'd0, num_of_ope}, 32'd0);
    check_eq("rst_valid", {31'd0, ope_valid}, 32'd0);
    check_eq("rst_illegal", {31'd0, illegal}, 32'd0);

    // 1-byte opcode, zero wait: ope_valid two cycles after mem_req rises
    reset = 1'b0;
    ope_ready = 1'b1;
    step();
    check_eq("t1_req_rise", {31'd0, mem_req}, 32'd1);
    step();
    check_eq("t1_valid_c1", {31'd0, ope_valid}, 32'd0);
    step();
    check_eq("t1_valid_c2", {31'd0, ope_valid}, 32'd1);
    check_eq("t1_ope", ope, 32'h55000000);
    check_eq("t1_num", {28'd0, num_of_ope}, 32'd1);
    check_eq("t1_req_low", {31'd0, mem_req}, 32'd0);
    step();
    check_eq("t1_next_addr", mem_addr, 32'h1);
    check_eq("t1_valid_fall", {31'd0, ope_valid}, 32'd0);

    // Redirect to 0x10 with a byte arriving the same cycle (dropped)
    eip_load = 1'b1; eip_in = 32'h10;
    step();
    eip_load = 1'b0;
    check_eq("redir_addr", mem_addr, 32'h10);

    // 5-byte instruction, 5th byte discarded
    wait_valid("t2", fetches);
    check_eq("t2_fetches", fetches, 32'd5);
    check_eq("t2_ope", ope, 32'he8f0ffff);
    check_eq("t2_num", {28'd0, num_of_ope}, 32'd5);
    check_eq("t2_illegal", {31'd0, illegal}, 32'd0);
    step();
    check_eq("t2_next_addr", mem_addr, 32'h15);

    // 3-byte instruction held while consumer stalls
    ope_ready = 1'b0;
    wait_valid("t3", fetches);
    check_eq("t3_fetches", fetches, 32'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t3_hold_ope", ope, 32'h8b45fc00);
      check_eq("t3_hold_valid", {31'd0, ope_valid}, 32'd1);
      check_eq("t3_hold_noreq", {31'd0, mem_req}, 32'd0);
    end
    ope_ready = 1'b1;
    step();
    check_eq("t3_next_addr", mem_addr, 32'h18);
    check_eq("t3_req", {31'd0, mem_req}, 32'd1);

    // Two memory wait cycles add two cycles of latency
    stall = 1'b1;
    step();
    step();
    check_eq("ws_req_held", {31'd0, mem_req}, 32'd1);
    check_eq("ws_addr_held", mem_addr, 32'h18);
    stall = 1'b0;
    step();
    check_eq("ws_valid_c1", {31'd0, ope_valid}, 32'd0);
    step();
    check_eq("ws_valid_c2", {31'd0, ope_valid}, 32'd1);
    check_eq("ws_ope", ope, 32'h5d000000);
    step();
    check_eq("ws_next_addr", mem_addr, 32'h19);

    // Redirect during FETCH_ARG of b8 discards the partial instruction
    step();
    step();
    check_eq("t4_mid_addr", mem_addr, 32'h1b);
    eip_load = 1'b1; eip_in = 32'h40;
    step();
    eip_load = 1'b0;
    check_eq("t4_addr", mem_addr, 32'h40);
    check_eq("t4_novalid", {31'd0, ope_valid}, 32'd0);
    wait_valid("t4", fetches);
    check_eq("t4_ope", ope, 32'hc3000000);
    check_eq("t4_num", {28'd0, num_of_ope}, 32'd1);
    step();
    check_eq("t4_next_addr", mem_addr, 32'h41);

    // Illegal opcode at 5
    eip_load = 1'b1; eip_in = 32'h5;
    step();
    eip_load = 1'b0;
    wait_valid("t5", fetches);
    check_eq("t5_ope", ope, 32'h0f000000);
    check_eq("t5_num", {28'd0, num_of_ope}, 32'd1);
    check_eq("t5_illegal", {31'd0, illegal}, 32'd1);
    step();
`ifdef ALIGN_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_trap_noreq", {31'd0, mem_req}, 32'd0);
      check_eq("t5_trap_novalid", {31'd0, ope_valid}, 32'd0);
      check_eq("t5_trap_illegal", {31'd0, illegal}, 32'd1);
      step();
    end
`else
    check_eq("t5_resume_addr", mem_addr, 32'h6);
    check_eq("t5_resume_req", {31'd0, mem_req}, 32'd1);
    check_eq("t5_illegal_clr", {31'd0, illegal}, 32'd0);
`endif

    // pc wrap from ffffffff to 0
    mem[8'h00] = 8'h02;
    mem[8'h01] = 8'h53;
    eip_load = 1'b1; eip_in = 32'hffffffff;
    step();
    eip_load = 1'b0;
    check_eq("t6_addr", mem_addr, 32'hffffffff);
    check_eq("t6_illegal_clr", {31'd0, illegal}, 32'd0);
    wait_valid("t6", fetches);
    check_eq("t6_fetches", fetches, 32'd2);
    check_eq("t6_ope", ope, 32'h6a020000);
    check_eq("t6_num", {28'd0, num_of_ope}, 32'd2);
    step();
    check_eq("t6_next_addr", mem_addr, 32'h1);

    // Redirect simultaneous with a transfer: redirect wins for pc
    wait_valid("t7", fetches);
    check_eq("t7_ope", ope, 32'h53000000);
    eip_load = 1'b1; eip_in = 32'h80;
    step();
    eip_load = 1'b0;
    check_eq("t7_addr", mem_addr, 32'h80);
    check_eq("t7_valid_fall", {31'd0, ope_valid}, 32'd0);

    // Reset mid-fetch abandons the request
    stall = 1'b1;
    step();
    reset = 1'b1;
    #1;
    check_eq("t8_req_rst", {31'd0, mem_req}, 32'd0);
    check_eq("t8_addr_rst", mem_addr, 32'h0);
    step();
    reset = 1'b0;
    stall = 1'b0;
    step();
    check_eq("t8_req_rise", {31'd0, mem_req}, 32'd1);
    check_eq("t8_addr", mem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ope_fetch_aligner.md
OPE_FETCH_ALIGNER -- requirements
Module: ope_fetch_aligner

Interface
REQ-001 Parameter RESET_EIP, 32'h00000000, fetch address loaded at reset.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mem_addr  output  32  byte address of the current fetch request.
REQ-005 mem_req  output  1  fetch request; held with mem_addr stable until mem_valid.
REQ-006 mem_data  input  8  returned instruction byte.
REQ-007 mem_valid  input  1  mem_data valid this cycle; ignored when mem_req=0.
REQ-008 eip_load  input  1  redirect fetch (call/ret/leave result).
REQ-009 eip_in  input  32  redirect target, sampled when eip_load=1.
REQ-010 ope  output  32  assembled instruction, opcode at [31:24], following bytes at [23:16], [15:8], [7:0]; unused lanes zero.
REQ-011 num_of_ope  output  4  instruction length in bytes.
REQ-012 ope_valid  output  1  ope/num_of_ope valid and held.
REQ-013 ope_ready  input  1  consumer accepts; transfer when ope_valid and ope_ready both 1.
REQ-014 illegal  output  1  opcode not in length table.

Function
REQ-015 Length table: 55,53,5d,c3,c9 -> 1; 89,6a -> 2; 8b,83 -> 3; b8,e8 -> 5; any other -> 1 with illegal=1.
REQ-016 States: FETCH_OP, FETCH_ARG, SKIP, PRESENT, TRAP (TRAP only with macro, REQ-027).
REQ-017 FETCH_OP: mem_req=1, mem_addr=pc; on mem_valid latch byte into ope[31:24], clear ope[23:0], pc+1, set num_of_ope; length 1 -> PRESENT, else FETCH_ARG.
REQ-018 FETCH_ARG: byte k (k=1..3) written to lane ope[31-8k:24-8k], pc+1 per accepted byte; after byte min(len-1,3) go to PRESENT if len<=4, else SKIP.
REQ-019 SKIP: fetch and discard the 5th byte, pc+1, then PRESENT.
REQ-020 PRESENT: ope_valid=1, mem_req=0, outputs held stable; on ope_ready -> FETCH_OP same edge, ope_valid falls next cycle.
REQ-021 Minimum latency: 1-byte instruction with zero-wait memory gives ope_valid 2 cycles after mem_req first asserts; each memory wait cycle adds 1.
REQ-022 pc is 32-bit, wraps ffffffff -> 00000000 without flag.
REQ-023 eip_load in any state: pc <= eip_in, ope_valid <= 0, illegal <= 0, partial instruction discarded, state <= FETCH_OP; a mem_valid in the same cycle is dropped.
REQ-024 eip_load simultaneous with an ope_valid&ope_ready transfer: transfer completes, redirect still wins for pc.
REQ-025 No instruction is presented twice; each transfer advances exactly num_of_ope bytes of pc.

Reset
REQ-026 On reset: pc=RESET_EIP, state=FETCH_OP, ope=0, num_of_ope=0, ope_valid=0, illegal=0, mem_req=0 during reset, mem_addr=RESET_EIP; mem_req rises first cycle after release; reset mid-fetch abandons the request.

Configuration
REQ-027 Macro ALIGN_ILLEGAL_TRAP_EN: defined -> illegal opcode presented once with illegal=1, then FSM enters TRAP (mem_req=0, ope_valid=0, illegal=1 held) until reset or eip_load; undefined -> illegal opcode presented as 1-byte instruction with illegal=1 for that transfer only, fetch continues.

Verification
REQ-028 Bytes 55 at addr 0, ready=1, zero wait -> ope=55000000, num_of_ope=1, ope_valid 2 cycles after mem_req, next mem_addr=1.
REQ-029 Bytes e8 f0 ff ff ff at addr 10 -> ope=e8f0ffff, num_of_ope=5, 5 fetches, next mem_addr=15.
REQ-030 Bytes 8b 45 fc, ope_ready held 0 for 4 cycles -> ope=8b45fc00 stable, ope_valid held, no mem_req until ready.
REQ-031 eip_load=1, eip_in=00000040 during FETCH_ARG of b8 -> partial discarded, next mem_addr=40, no ope_valid for b8.
REQ-032 Opcode 0f at addr 5: macro defined -> illegal=1, then TRAP, mem_req stays 0; undefined -> ope=0f000000, num_of_ope=1, fetch resumes at 6.
REQ-033 pc=ffffffff, byte 6a then 02 at 0 -> ope=6a020000, num_of_ope=2, next mem_addr=00000001.
